jedro_1_mem_arbiter: RTL and testbench
======================================

Name: jedro_1_mem_arbiter

Overview:
2:1 request/response arbiter that lets the jedro_1_top instruction port (port 0) and data port (port 1) share one bytewrite_sram_wrap instance. It selects one requester per cycle and forwards its request to the memory. A tag FIFO records which port issued each accepted request, so in-order memory responses route back to the correct requester. The block adds no cycle to either the request path or the response path.

Parameters:
DATA_WIDTH, 32, width of address and data buses
MAX_OUTSTANDING, 4, depth of the tag FIFO (accepted requests with no response yet); power of two, minimum 2
PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, data port (port 1) wins

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
s0_req_addr_i/s0_req_data_i  in  DATA_WIDTH  instruction-port request address/write data
s0_req_strobe_i  in  4  byte strobes
s0_req_write_i, s0_req_valid_i  in  1  write flag, request valid
s0_req_ready_o  out  1  request accepted
s0_rsp_data_o  out  DATA_WIDTH  response data
s0_rsp_err_o, s0_rsp_valid_o  out  1  response error, response valid
s0_rsp_ready_i  in  1  requester accepts response
s1_*  (same set and directions as s0_*)  data port
m_req_addr_o/m_req_data_o  out  DATA_WIDTH  request to memory
m_req_strobe_o  out  4; m_req_write_o, m_req_valid_o  out  1
m_req_ready_i  in  1
m_rsp_data_i  in  DATA_WIDTH; m_rsp_err_i, m_rsp_valid_i  in  1
m_rsp_ready_o  out  1
unexp_rsp_o  out  1  sticky flag: a response arrived while no request was outstanding

Behaviour:
- Handshake on every channel: transfer happens when valid&&ready on a rising clk_i edge. Requesters hold their request fields stable while valid is high and not yet accepted.
- Arbitration FSM, states IDLE, HOLD0, HOLD1:
  - IDLE: pick a winner from valid requests.
    - PRIORITY_MODE=0: a single valid port wins. If both are valid, the port not stored in last_grant wins.
    - PRIORITY_MODE=1: port 1 wins any tie.
  - If the winner is offered (m_req_valid_o=1) and m_req_ready_i=0, go to HOLD<winner>.
  - HOLDn: the grant is locked to port n until the m_req handshake, then return to IDLE. The other port's valid is ignored while locked.
  - last_grant updates only on an m_req handshake.
- Request mux is combinational:
  - m_req_* = the granted port's fields.
  - m_req_valid_o = granted valid && !fifo_full.
  - s<granted>_req_ready_o = m_req_ready_i && !fifo_full. The losing port's ready is 0.
- Tag FIFO (MAX_OUTSTANDING entries, 1-bit tag):
  - Push the granted port id on an m_req handshake.
  - Pop on an m_rsp handshake.
  - If full, requests are stalled even when a pop occurs in the same cycle (ready is computed from the registered count).
  - If a push and a pop occur together, the count is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing, combinational from the FIFO head tag h:
  - s<h>_rsp_valid_o = m_rsp_valid_i && !fifo_empty.
  - s<h>_rsp_data_o and s<h>_rsp_err_o are driven from m_rsp_*. The non-head port's data/err outputs are 0.
  - m_rsp_ready_o = s<h>_rsp_ready_i.
- FIFO empty while m_rsp_valid_i=1: m_rsp_ready_o=1, the response is dropped, and unexp_rsp_o is set. unexp_rsp_o is cleared only by reset.
- Reset (rst_i=1 at a clock edge):
  - State=IDLE, FIFO empty, last_grant=1 (so port 0 wins the first tie), unexp_rsp_o=0.
  - All ready and valid outputs are 0 while rst_i=1.
  - Any in-flight requests and responses are discarded.
- A port may issue a new request in the same cycle its earlier response is delivered.

Test Plan:
- Port 0 alone issues a read of addr 0x100; memory is ready and responds next cycle with 0xDEADBEEF -> s0_rsp_valid_o=1 with data 0xDEADBEEF one cycle after the request handshake; s1_rsp_valid_o stays 0.
- Both ports valid every cycle, PRIORITY_MODE=0, memory always ready -> grants alternate 0,1,0,1 starting with port 0; the tag FIFO routes each response to its issuer.
- Same stimulus with PRIORITY_MODE=1 -> port 1 is granted every cycle and s0_req_ready_o stays 0.
- Port 0 offered while m_req_ready_i is held 0 for 3 cycles, then port 1 raises valid -> grant stays on port 0 (HOLD0) until the handshake; port 1 is granted next.
- Memory withholds responses; port 1 issues 5 writes -> exactly 4 are accepted, then s1_req_ready_o=0; after one m_rsp handshake the 5th is accepted the following cycle.
- m_rsp_valid_i pulses with nothing outstanding -> m_rsp_ready_o=1, unexp_rsp_o=1 and sticky. Asserting rst_i with 2 requests outstanding -> FIFO empty, unexp_rsp_o=0, and port 0 wins the next tie.

Source files
------------

// File: rtl/jedro_1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// jedro_1_mem_arbiter
//
// Lets the jedro_1_top instruction port (s0) and data port (s1) share one
// bytewrite_sram_wrap. One requester is chosen per cycle and its request is
// forwarded combinationally to the memory. A small tag FIFO remembers which
// port issued each accepted request, so the in-order memory responses are
// routed back to the right requester. Neither path gains a cycle of latency.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   s0_req_* / s0_rsp_*     instruction-port request / response channel
//   s1_req_* / s1_rsp_*     data-port request / response channel
//   m_req_* / m_rsp_*       shared memory request / response channel
//   unexp_rsp_o             sticky: a response arrived with nothing outstanding
//
// Parameters
//   DATA_WIDTH       address and data bus width
//   MAX_OUTSTANDING  tag FIFO depth (power of two, >= 2)
//   PRIORITY_MODE    0 = round-robin, 1 = port 1 wins every tie
// -----------------------------------------------------------------------------
module jedro_1_mem_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned PRIORITY_MODE   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [DATA_WIDTH-1:0] s0_req_addr_i,
    input  logic [DATA_WIDTH-1:0] s0_req_data_i,
    input  logic [3:0]            s0_req_strobe_i,
    input  logic                  s0_req_write_i,
    input  logic                  s0_req_valid_i,
    output logic                  s0_req_ready_o,
    output logic [DATA_WIDTH-1:0] s0_rsp_data_o,
    output logic                  s0_rsp_err_o,
    output logic                  s0_rsp_valid_o,
    input  logic                  s0_rsp_ready_i,

    input  logic [DATA_WIDTH-1:0] s1_req_addr_i,
    input  logic [DATA_WIDTH-1:0] s1_req_data_i,
    input  logic [3:0]            s1_req_strobe_i,
    input  logic                  s1_req_write_i,
    input  logic                  s1_req_valid_i,
    output logic                  s1_req_ready_o,
    output logic [DATA_WIDTH-1:0] s1_rsp_data_o,
    output logic                  s1_rsp_err_o,
    output logic                  s1_rsp_valid_o,
    input  logic                  s1_rsp_ready_i,

    output logic [DATA_WIDTH-1:0] m_req_addr_o,
    output logic [DATA_WIDTH-1:0] m_req_data_o,
    output logic [3:0]            m_req_strobe_o,
    output logic                  m_req_write_o,
    output logic                  m_req_valid_o,
    input  logic                  m_req_ready_i,
    input  logic [DATA_WIDTH-1:0] m_rsp_data_i,
    input  logic                  m_rsp_err_i,
    input  logic                  m_rsp_valid_i,
    output logic                  m_rsp_ready_o,

    output logic                  unexp_rsp_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             unexp_rsp_q, unexp_rsp_d;
    logic             tag_mem_q [MAX_OUTSTANDING];

    logic grant;
    logic granted_valid;
    logic req_ready;
    logic fifo_full;
    logic fifo_empty;
    logic req_hs;
    logic rsp_hs;
    logic pop;
    logic head;

    // Winner selection. While a HOLD state is active the grant is locked so
    // an offered request is never withdrawn before memory takes it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant = 1'b0;
        case (state_q)
            HOLD0: grant = 1'b0;
            HOLD1: grant = 1'b1;
            default: begin
                if (s0_req_valid_i && s1_req_valid_i) begin
                    grant = (PRIORITY_MODE != 0) ? 1'b1 : ~last_grant_q;
                end else begin
                    grant = s1_req_valid_i;
                end
            end
        endcase
    end

    // Fullness comes from the registered count only, so a pop in the same
    // cycle does not reopen the request path.
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    assign granted_valid  = grant ? s1_req_valid_i : s0_req_valid_i;
    assign m_req_valid_o  = !rst_i && granted_valid && !fifo_full;
    assign m_req_addr_o   = grant ? s1_req_addr_i   : s0_req_addr_i;
    assign m_req_data_o   = grant ? s1_req_data_i   : s0_req_data_i;
    assign m_req_strobe_o = grant ? s1_req_strobe_i : s0_req_strobe_i;
    assign m_req_write_o  = grant ? s1_req_write_i  : s0_req_write_i;

    assign req_ready      = !rst_i && m_req_ready_i && !fifo_full;
    assign s0_req_ready_o = req_ready && !grant;
    assign s1_req_ready_o = req_ready && grant;
    assign req_hs         = m_req_valid_o && m_req_ready_i;

    // Response routing follows the oldest outstanding tag. With nothing
    // outstanding the response is swallowed so memory cannot stall.
    assign head           = tag_mem_q[rd_ptr_q];
    assign m_rsp_ready_o  = !rst_i && (fifo_empty || (head ? s1_rsp_ready_i : s0_rsp_ready_i));
    assign s0_rsp_valid_o = !rst_i && m_rsp_valid_i && !fifo_empty && !head;
    assign s1_rsp_valid_o = !rst_i && m_rsp_valid_i && !fifo_empty && head;
    assign s0_rsp_data_o  = head ? '0 : m_rsp_data_i;
    assign s1_rsp_data_o  = head ? m_rsp_data_i : '0;
    assign s0_rsp_err_o   = !head && m_rsp_err_i;
    assign s1_rsp_err_o   = head && m_rsp_err_i;
    assign rsp_hs         = m_rsp_valid_i && m_rsp_ready_o;
    assign pop            = rsp_hs && !fifo_empty;

    assign unexp_rsp_o    = unexp_rsp_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        unexp_rsp_d  = unexp_rsp_q;

        case (state_q)
            IDLE: begin
                if (m_req_valid_o && !m_req_ready_i) begin
                    state_d = grant ? HOLD1 : HOLD0;
                end
            end
            HOLD0, HOLD1: begin
                if (req_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_hs) begin
            last_grant_d = grant;
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({req_hs, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (m_rsp_valid_i && fifo_empty) begin
            unexp_rsp_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            unexp_rsp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            unexp_rsp_q  <= unexp_rsp_d;
        end
    end

    // NOTE: tag storage is not reset; an entry is only read while count_q marks it as live.
    always_ff @(posedge clk_i) begin
        if (req_hs) begin
            tag_mem_q[wr_ptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_mem_arbiter
//
// Directed bench for jedro_1_mem_arbiter. Two instances share every input:
// dut uses round-robin arbitration, dut_p uses fixed priority. The bench
// plays the memory; each accepted request pushes its expected response
// (issuing port, data, error) into a queue that is popped when the response
// is routed back.
// -----------------------------------------------------------------------------
module tb_jedro_1_mem_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } sb_t;

    logic        clk;
    logic        rst_i;

    logic [31:0] s0_req_addr_i, s0_req_data_i;
    logic [3:0]  s0_req_strobe_i;
    logic        s0_req_write_i, s0_req_valid_i, s0_rsp_ready_i;
    logic [31:0] s1_req_addr_i, s1_req_data_i;
    logic [3:0]  s1_req_strobe_i;
    logic        s1_req_write_i, s1_req_valid_i, s1_rsp_ready_i;
    logic        m_req_ready_i;
    logic [31:0] m_rsp_data_i;
    logic        m_rsp_err_i, m_rsp_valid_i;

    logic        s0_req_ready_o, s0_rsp_err_o, s0_rsp_valid_o;
    logic [31:0] s0_rsp_data_o;
    logic        s1_req_ready_o, s1_rsp_err_o, s1_rsp_valid_o;
    logic [31:0] s1_rsp_data_o;
    logic [31:0] m_req_addr_o, m_req_data_o;
    logic [3:0]  m_req_strobe_o;
    logic        m_req_write_o, m_req_valid_o, m_rsp_ready_o, unexp_rsp_o;

    logic        s0_req_ready_p, s0_rsp_err_p, s0_rsp_valid_p;
    logic [31:0] s0_rsp_data_p;
    logic        s1_req_ready_p, s1_rsp_err_p, s1_rsp_valid_p;
    logic [31:0] s1_rsp_data_p;
    logic [31:0] m_req_addr_p, m_req_data_p;
    logic [3:0]  m_req_strobe_p;
    logic        m_req_write_p, m_req_valid_p, m_rsp_ready_p, unexp_p;

    int n_checks = 0;
    int n_fail   = 0;
    sb_t sb_q[$];

    jedro_1_mem_arbiter #(.DATA_WIDTH(32), .MAX_OUTSTANDING(4), .PRIORITY_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s0_req_addr_i(s0_req_addr_i), .s0_req_data_i(s0_req_data_i),
        .s0_req_strobe_i(s0_req_strobe_i), .s0_req_write_i(s0_req_write_i),
        .s0_req_valid_i(s0_req_valid_i), .s0_req_ready_o(s0_req_ready_o),
        .s0_rsp_data_o(s0_rsp_data_o), .s0_rsp_err_o(s0_rsp_err_o),
        .s0_rsp_valid_o(s0_rsp_valid_o), .s0_rsp_ready_i(s0_rsp_ready_i),
        .s1_req_addr_i(s1_req_addr_i), .s1_req_data_i(s1_req_data_i),
        .s1_req_strobe_i(s1_req_strobe_i), .s1_req_write_i(s1_req_write_i),
        .s1_req_valid_i(s1_req_valid_i), .s1_req_ready_o(s1_req_ready_o),
        .s1_rsp_data_o(s1_rsp_data_o), .s1_rsp_err_o(s1_rsp_err_o),
        .s1_rsp_valid_o(s1_rsp_valid_o), .s1_rsp_ready_i(s1_rsp_ready_i),
        .m_req_addr_o(m_req_addr_o), .m_req_data_o(m_req_data_o),
        .m_req_strobe_o(m_req_strobe_o), .m_req_write_o(m_req_write_o),
        .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i),
        .m_rsp_data_i(m_rsp_data_i), .m_rsp_err_i(m_rsp_err_i),
        .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_ready_o(m_rsp_ready_o),
        .unexp_rsp_o(unexp_rsp_o)
    );

    jedro_1_mem_arbiter #(.DATA_WIDTH(32), .MAX_OUTSTANDING(4), .PRIORITY_MODE(1)) dut_p (
        .clk_i(clk), .rst_i(rst_i),
        .s0_req_addr_i(s0_req_addr_i), .s0_req_data_i(s0_req_data_i),
        .s0_req_strobe_i(s0_req_strobe_i), .s0_req_write_i(s0_req_write_i),
        .s0_req_valid_i(s0_req_valid_i), .s0_req_ready_o(s0_req_ready_p),
        .s0_rsp_data_o(s0_rsp_data_p), .s0_rsp_err_o(s0_rsp_err_p),
        .s0_rsp_valid_o(s0_rsp_valid_p), .s0_rsp_ready_i(s0_rsp_ready_i),
        .s1_req_addr_i(s1_req_addr_i), .s1_req_data_i(s1_req_data_i),
        .s1_req_strobe_i(s1_req_strobe_i), .s1_req_write_i(s1_req_write_i),
        .s1_req_valid_i(s1_req_valid_i), .s1_req_ready_o(s1_req_ready_p),
        .s1_rsp_data_o(s1_rsp_data_p), .s1_rsp_err_o(s1_rsp_err_p),
        .s1_rsp_valid_o(s1_rsp_valid_p), .s1_rsp_ready_i(s1_rsp_ready_i),
        .m_req_addr_o(m_req_addr_p), .m_req_data_o(m_req_data_p),
        .m_req_strobe_o(m_req_strobe_p), .m_req_write_o(m_req_write_p),
        .m_req_valid_o(m_req_valid_p), .m_req_ready_i(m_req_ready_i),
        .m_rsp_data_i(m_rsp_data_i), .m_rsp_err_i(m_rsp_err_i),
        .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_ready_o(m_rsp_ready_p),
        .unexp_rsp_o(unexp_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by the bench: one fixed word, the rest derived
    // from the address. Address bit 2 flags an error response.
    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled a few time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic port, input logic [31:0] addr);
        sb_t e;
        e.port = port;
        e.data = mem_rd(addr);
        e.err  = addr[2];
        sb_q.push_back(e);
    endtask

    task automatic drive_rsp();
        if (sb_q.size() != 0) begin
            m_rsp_valid_i = 1'b1;
            m_rsp_data_i  = sb_q[0].data;
            m_rsp_err_i   = sb_q[0].err;
        end
    endtask

    task automatic rsp_check();
        sb_t e;
        check1("sb_pending", sb_q.size() != 0, 1'b1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check1("rsp0_valid", s0_rsp_valid_o, !e.port);
        check1("rsp1_valid", s1_rsp_valid_o, e.port);
        check("rsp_data", e.port ? s1_rsp_data_o : s0_rsp_data_o, e.data);
        check1("rsp_err", e.port ? s1_rsp_err_o : s0_rsp_err_o, e.err);
        check("rsp_other_data", e.port ? s0_rsp_data_o : s1_rsp_data_o, 32'h0);
        check1("m_rsp_ready", m_rsp_ready_o, 1'b1);
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        s0_req_valid_i = 1'b0;
        s1_req_valid_i = 1'b0;
        m_rsp_valid_i  = 1'b0;
        m_req_ready_i  = 1'b1;
        cyc();
        rst_i = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        rst_i           = 1'b1;
        s0_req_addr_i   = 32'h0000_0100;
        s0_req_data_i   = 32'h0;
        s0_req_strobe_i = 4'h0;
        s0_req_write_i  = 1'b0;
        s0_req_valid_i  = 1'b1;
        s0_rsp_ready_i  = 1'b1;
        s1_req_addr_i   = 32'h0;
        s1_req_data_i   = 32'h0;
        s1_req_strobe_i = 4'h0;
        s1_req_write_i  = 1'b0;
        s1_req_valid_i  = 1'b0;
        s1_rsp_ready_i  = 1'b1;
        m_req_ready_i   = 1'b1;
        m_rsp_data_i    = 32'h0;
        m_rsp_err_i     = 1'b0;
        m_rsp_valid_i   = 1'b0;

        // Outputs held quiet while reset is asserted, even with a valid request.
        cyc();
        #1;
        check1("rst_s0_ready", s0_req_ready_o, 1'b0);
        check1("rst_m_valid", m_req_valid_o, 1'b0);
        check1("rst_m_rsp_ready", m_rsp_ready_o, 1'b0);
        cyc();
        rst_i = 1'b0;

        // Port 0 reads 0x100; response one cycle after the handshake.
        #1;
        check1("t1_m_valid", m_req_valid_o, 1'b1);
        check("t1_m_addr", m_req_addr_o, 32'h0000_0100);
        check1("t1_s0_ready", s0_req_ready_o, 1'b1);
        check1("t1_s1_ready", s1_req_ready_o, 1'b0);
        check1("t1_unexp", unexp_rsp_o, 1'b0);
        push_exp(1'b0, 32'h0000_0100);
        cyc();
        s0_req_valid_i = 1'b0;
        drive_rsp();
        #1;
        check("t1_rsp_word", s0_rsp_data_o, 32'hDEAD_BEEF);
        rsp_check();
        cyc();
        m_rsp_valid_i = 1'b0;

        // Grant locked on port 0 while memory stalls; port 1 (which would win
        // a tie now, since port 0 was granted last) must wait.
        s0_req_valid_i = 1'b1;
        s0_req_addr_i  = 32'h0000_0300;
        m_req_ready_i  = 1'b0;
        #1;
        check1("t4_m_valid", m_req_valid_o, 1'b1);
        check("t4_addr_a", m_req_addr_o, 32'h0000_0300);
        check1("t4_s0_ready_stall", s0_req_ready_o, 1'b0);
        cyc();
        s1_req_valid_i = 1'b1;
        s1_req_addr_i  = 32'h0000_0404;
        #1;
        check("t4_addr_b", m_req_addr_o, 32'h0000_0300);
        check1("t4_s1_ready_b", s1_req_ready_o, 1'b0);
        cyc();
        #1;
        check("t4_addr_c", m_req_addr_o, 32'h0000_0300);
        cyc();
        m_req_ready_i = 1'b1;
        #1;
        check("t4_addr_d", m_req_addr_o, 32'h0000_0300);
        check1("t4_s0_ready_d", s0_req_ready_o, 1'b1);
        check1("t4_s1_ready_d", s1_req_ready_o, 1'b0);
        push_exp(1'b0, 32'h0000_0300);
        cyc();
        s0_req_valid_i = 1'b0;
        drive_rsp();
        #1;
        check("t4_addr_e", m_req_addr_o, 32'h0000_0404);
        check1("t4_s1_ready_e", s1_req_ready_o, 1'b1);
        rsp_check();
        push_exp(1'b1, 32'h0000_0404);
        cyc();
        s1_req_valid_i = 1'b0;
        drive_rsp();
        #1;
        rsp_check();
        cyc();
        m_rsp_valid_i = 1'b0;

        // Both ports valid every cycle, memory always ready. dut alternates
        // 0,1,0,...; dut_p grants port 1 every time.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s0_req_valid_i = 1'b1;
            s1_req_valid_i = 1'b1;
            s0_req_addr_i  = 32'h0000_1000 + 32'(4 * i);
            s1_req_addr_i  = 32'h0000_2000 + 32'(4 * i);
            if (i > 0) drive_rsp();
            #1;
            check("t2_m_addr", m_req_addr_o, (i % 2 == 0) ? s0_req_addr_i : s1_req_addr_i);
            check1("t2_s0_ready", s0_req_ready_o, i % 2 == 0);
            check1("t2_s1_ready", s1_req_ready_o, i % 2 == 1);
            check("t3_m_addr", m_req_addr_p, s1_req_addr_i);
            check1("t3_s0_ready", s0_req_ready_p, 1'b0);
            check1("t3_s1_ready", s1_req_ready_p, 1'b1);
            if (i > 0) begin
                check1("t3_rsp1_valid", s1_rsp_valid_p, 1'b1);
                check1("t3_rsp0_valid", s0_rsp_valid_p, 1'b0);
                check("t3_rsp1_data", s1_rsp_data_p, sb_q[0].data);
                rsp_check();
            end
            push_exp((i % 2) == 1, (i % 2 == 0) ? s0_req_addr_i : s1_req_addr_i);
            cyc();
        end
        s0_req_valid_i = 1'b0;
        s1_req_valid_i = 1'b0;
        drive_rsp();
        #1;
        check1("t3_rsp1_valid_last", s1_rsp_valid_p, 1'b1);
        rsp_check();
        cyc();
        m_rsp_valid_i = 1'b0;

        // Memory withholds responses: four writes fill the tag FIFO, the
        // fifth stalls (even across a pop) and goes the cycle after the pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s1_req_valid_i  = 1'b1;
            s1_req_write_i  = 1'b1;
            s1_req_addr_i   = 32'h0000_0500 + 32'(4 * i);
            s1_req_data_i   = 32'h1111_0000 + 32'(i);
            s1_req_strobe_i = 4'h1 << i;
            #1;
            check1("t5_s1_ready", s1_req_ready_o, 1'b1);
            check1("t5_m_write", m_req_write_o, 1'b1);
            check("t5_m_data", m_req_data_o, s1_req_data_i);
            check("t5_m_strobe", 32'(m_req_strobe_o), 32'(s1_req_strobe_i));
            push_exp(1'b1, s1_req_addr_i);
            cyc();
        end
        s1_req_addr_i   = 32'h0000_0510;
        s1_req_data_i   = 32'h1111_0004;
        s1_req_strobe_i = 4'hF;
        #1;
        check1("t5_full_ready", s1_req_ready_o, 1'b0);
        check1("t5_full_m_valid", m_req_valid_o, 1'b0);
        cyc();
        drive_rsp();
        #1;
        check1("t5_full_pop_ready", s1_req_ready_o, 1'b0);
        rsp_check();
        cyc();
        m_rsp_valid_i = 1'b0;
        #1;
        check1("t5_fifth_ready", s1_req_ready_o, 1'b1);
        check("t5_fifth_addr", m_req_addr_o, 32'h0000_0510);
        push_exp(1'b1, 32'h0000_0510);
        cyc();
        s1_req_valid_i = 1'b0;
        s1_req_write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rsp();
            #1;
            rsp_check();
            cyc();
        end
        m_rsp_valid_i = 1'b0;
        #1;
        check("t5_drained", 32'(sb_q.size()), 32'd0);

        // Response with nothing outstanding is swallowed and flagged.
        s0_rsp_ready_i = 1'b0;
        s1_rsp_ready_i = 1'b0;
        m_rsp_valid_i  = 1'b1;
        m_rsp_data_i   = 32'h1234_5678;
        #1;
        check1("t6_m_rsp_ready", m_rsp_ready_o, 1'b1);
        check1("t6_rsp0_valid", s0_rsp_valid_o, 1'b0);
        check1("t6_rsp1_valid", s1_rsp_valid_o, 1'b0);
        check1("t6_unexp_before", unexp_rsp_o, 1'b0);
        cyc();
        m_rsp_valid_i  = 1'b0;
        s0_rsp_ready_i = 1'b1;
        s1_rsp_ready_i = 1'b1;
        #1;
        check1("t6_unexp_set", unexp_rsp_o, 1'b1);
        cyc();
        cyc();
        #1;
        check1("t6_unexp_sticky", unexp_rsp_o, 1'b1);

        // Two requests left outstanding (port 1 then port 0), then reset.
        s1_req_valid_i = 1'b1;
        s1_req_addr_i  = 32'h0000_0600;
        #1;
        check1("t6_s1_issue", s1_req_ready_o, 1'b1);
        cyc();
        s1_req_valid_i = 1'b0;
        s0_req_valid_i = 1'b1;
        s0_req_addr_i  = 32'h0000_0700;
        #1;
        check1("t6_s0_issue", s0_req_ready_o, 1'b1);
        cyc();
        rst_i          = 1'b1;
        s0_req_addr_i  = 32'h0000_0800;
        s1_req_addr_i  = 32'h0000_0900;
        s1_req_valid_i = 1'b1;
        m_rsp_valid_i  = 1'b1;
        m_rsp_data_i   = mem_rd(32'h0000_0600);
        #1;
        check1("t6_rst_s0_ready", s0_req_ready_o, 1'b0);
        check1("t6_rst_s1_ready", s1_req_ready_o, 1'b0);
        check1("t6_rst_m_valid", m_req_valid_o, 1'b0);
        check1("t6_rst_m_rsp_ready", m_rsp_ready_o, 1'b0);
        check1("t6_rst_rsp1_valid", s1_rsp_valid_o, 1'b0);
        cyc();
        rst_i = 1'b0;
        #1;
        check1("t6_unexp_cleared", unexp_rsp_o, 1'b0);
        check("t6_tie_addr", m_req_addr_o, 32'h0000_0800);
        check1("t6_tie_s0_ready", s0_req_ready_o, 1'b1);
        check1("t6_tie_s1_ready", s1_req_ready_o, 1'b0);
        check1("t6_empty_rsp0", s0_rsp_valid_o, 1'b0);
        check1("t6_empty_rsp1", s1_rsp_valid_o, 1'b0);
        check1("t6_empty_m_rsp_ready", m_rsp_ready_o, 1'b1);
        cyc();
        s0_req_valid_i = 1'b0;
        s1_req_valid_i = 1'b0;
        m_rsp_valid_i  = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
